hicore_lsu_icb_master: RTL and testbench
========================================

# hicore_lsu_icb_master

ICB initiator for the HiCore load/store path. It accepts load and store requests from the execute stage and turns them into ICB commands with byte-lane write data and write masks. It tracks up to two outstanding transactions in order, and aligns and extends response data into write-back results. It drives the same ICB cmd/rsp channel that the DTCM controller responds on.

## Interface
- AW, 32, address width
- DW, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- lsu_req_valid  in  1  request valid
- lsu_req_ready  out  1  request accepted when valid&ready
- lsu_req_load  in  1  1=load, 0=store
- lsu_req_addr  in  AW  byte address
- lsu_req_wdata  in  DW  store data, right-aligned
- lsu_req_size  in  2  0=byte, 1=half, 2=word (3 reserved, treated as word)
- lsu_req_unsigned  in  1  load zero-extends when 1
- lsu_req_rd  in  5  destination register tag
- lsu_wb_valid / lsu_wb_ready  out / in  1  write-back handshake
- lsu_wb_rdata  out  DW  extended load data; 0 for stores
- lsu_wb_rd  out  5  tag of completing request
- lsu_wb_load  out  1  completing request was a load
- lsu_wb_err  out  1  bus error or misalign
- lsu_wb_misalign  out  1  misaligned-access exception
- mem_icb_cmd_valid / mem_icb_cmd_ready  out / in  1  ICB cmd handshake
- mem_icb_cmd_read  out  1  equals lsu_req_load
- mem_icb_cmd_addr  out  AW  lsu_req_addr unmodified
- mem_icb_cmd_wdata  out  DW  lane-replicated store data
- mem_icb_cmd_wmask  out  DW/8  byte-lane mask
- mem_icb_rsp_valid / mem_icb_rsp_ready  in / out  1  ICB rsp handshake
- mem_icb_rsp_err  in  1  response error
- mem_icb_rsp_rdata  in  DW  response data

## Operation
- Misalign: half with addr[0]=1, or word with addr[1:0]≠0. Misaligned requests never issue an ICB command.
- Tracker: 2-entry in-order FIFO. Entry fields: load, size, unsigned, off=addr[1:0], rd, misalign. Write and read pointers are 1 bit each and wrap. Occupancy counter is 0..2.
- Issue: mem_icb_cmd_valid = lsu_req_valid & ~full & ~misalign.
- Accept: lsu_req_ready = ~full & (misalign | mem_icb_cmd_ready).
- Push: on lsu_req_valid & lsu_req_ready, including misaligned requests. When full, push is blocked even if a pop happens in the same cycle.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Write mask: byte → 4'b0001<<off; half → 4'b0011<<off; word → 4'b1111. The same mask is driven for loads.
- Completion, head entry with misalign=1: lsu_wb_valid=1 with no ICB rsp; lsu_wb_err=1, lsu_wb_misalign=1, rdata=0.
- Completion, head entry with misalign=0:
  - lsu_wb_valid = mem_icb_rsp_valid.
  - mem_icb_rsp_ready = lsu_wb_ready.
  - lsu_wb_err = mem_icb_rsp_err.
- Load data: shift rsp_rdata right by off*8, then sign- or zero-extend from bit 7 (byte) or bit 15 (half). Word passes through. Store rdata = 0.
- Pop: on lsu_wb_valid & lsu_wb_ready. Push and pop may occur in the same cycle when not full; occupancy is then unchanged.
- Empty tracker: lsu_wb_valid=0 and mem_icb_rsp_ready=0. Unexpected rsp_valid is ignored and held off.

## Timing
- Command path is combinational from lsu_req_* (zero-cycle issue).
- Write-back is combinational from rsp and the head entry. With a DTCM responder, load result appears the cycle after cmd handshake.
- Reset (rst=1, asynchronous): pointers and occupancy clear to 0.
- While rst=1, these outputs are forced to 0: lsu_req_ready, mem_icb_cmd_valid, mem_icb_rsp_ready, lsu_wb_valid.
- Reset mid-operation discards all tracked entries; responses in flight are not awaited.
- Throughput: one request per cycle while occupancy<2 and the bus is ready. A third request stalls until a pop completes, then is accepted the following cycle.

## Test plan
- Store byte 0xA5 at 0x103 → cmd: read=0, wdata=0xA5A5A5A5, wmask=4'b1000. Then rsp → wb: load=0, rdata=0.
- Load byte signed at 0x102, rsp_rdata=0x0080FF00 → wb_rdata=0xFFFFFF80. Same request with unsigned=1 → 0x00000080.
- Load half unsigned at 0x202, rsp_rdata=0xBEEF1234 → wb_rdata=0x0000BEEF, wmask=4'b1100.
- Load word at 0x302 → no cmd_valid, req accepted, wb next cycle with err=1 and misalign=1, rd preserved.
- Three back-to-back loads with lsu_wb_ready=0 → first two issue, third sees lsu_req_ready=0. Release wb_ready → in-order wb and rd tags match, then third issues.
- Assert rst with two entries outstanding → outputs 0 immediately. After release, a new load completes normally and stale rsp is not written back.

Source files
------------

// File: rtl/hicore_lsu_icb_master_if.sv
// Bundles the execute-stage request, write-back and ICB cmd/rsp signals of the
// HiCore load/store unit; master is the LSU side, slave is the environment.
interface hicore_lsu_icb_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic            lsu_req_load;
  logic [AW-1:0]   lsu_req_addr;
  logic [DW-1:0]   lsu_req_wdata;
  logic [1:0]      lsu_req_size;
  logic            lsu_req_unsigned;
  logic [4:0]      lsu_req_rd;

  logic            lsu_wb_valid;
  logic            lsu_wb_ready;
  logic [DW-1:0]   lsu_wb_rdata;
  logic [4:0]      lsu_wb_rd;
  logic            lsu_wb_load;
  logic            lsu_wb_err;
  logic            lsu_wb_misalign;

  logic            mem_icb_cmd_valid;
  logic            mem_icb_cmd_ready;
  logic            mem_icb_cmd_read;
  logic [AW-1:0]   mem_icb_cmd_addr;
  logic [DW-1:0]   mem_icb_cmd_wdata;
  logic [DW/8-1:0] mem_icb_cmd_wmask;

  logic            mem_icb_rsp_valid;
  logic            mem_icb_rsp_ready;
  logic            mem_icb_rsp_err;
  logic [DW-1:0]   mem_icb_rsp_rdata;

  modport master (
    input  lsu_req_valid, lsu_req_load, lsu_req_addr, lsu_req_wdata,
           lsu_req_size, lsu_req_unsigned, lsu_req_rd,
    output lsu_req_ready,
    output lsu_wb_valid, lsu_wb_rdata, lsu_wb_rd, lsu_wb_load, lsu_wb_err,
           lsu_wb_misalign,
    input  lsu_wb_ready,
    output mem_icb_cmd_valid, mem_icb_cmd_read, mem_icb_cmd_addr,
           mem_icb_cmd_wdata, mem_icb_cmd_wmask,
    input  mem_icb_cmd_ready,
    input  mem_icb_rsp_valid, mem_icb_rsp_err, mem_icb_rsp_rdata,
    output mem_icb_rsp_ready
  );

  modport slave (
    output lsu_req_valid, lsu_req_load, lsu_req_addr, lsu_req_wdata,
           lsu_req_size, lsu_req_unsigned, lsu_req_rd,
    input  lsu_req_ready,
    input  lsu_wb_valid, lsu_wb_rdata, lsu_wb_rd, lsu_wb_load, lsu_wb_err,
           lsu_wb_misalign,
    output lsu_wb_ready,
    input  mem_icb_cmd_valid, mem_icb_cmd_read, mem_icb_cmd_addr,
           mem_icb_cmd_wdata, mem_icb_cmd_wmask,
    output mem_icb_cmd_ready,
    output mem_icb_rsp_valid, mem_icb_rsp_err, mem_icb_rsp_rdata,
    input  mem_icb_rsp_ready
  );
endinterface

// File: rtl/hicore_lsu_icb_master.sv
// LSU ICB initiator: issues load/store commands with lane data and masks, tracks
// up to two in-order transactions and turns responses into write-back results.
module hicore_lsu_icb_master (
  input  logic                            clk,
  input  logic                            rst,
  hicore_lsu_icb_master_if.master         bus
);
  localparam int DW = 32;

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       full;
  logic       empty;

  logic       ent_load     [2];
  logic [1:0] ent_size     [2];
  logic       ent_unsigned [2];
  logic [1:0] ent_off      [2];
  logic [4:0] ent_rd       [2];
  logic       ent_mis      [2];

  logic          req_mis;
  logic          push;
  logic          pop;
  logic          head_load;
  logic [1:0]    head_size;
  logic          head_unsigned;
  logic [1:0]    head_off;
  logic          head_mis;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_data;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  assign req_mis = ((bus.lsu_req_size == 2'd1) & bus.lsu_req_addr[0]) |
                   (bus.lsu_req_size[1] & (bus.lsu_req_addr[1:0] != 2'b00));

  // Misaligned requests are absorbed into the tracker without touching the bus.
  assign bus.lsu_req_ready     = ~rst & ~full & (req_mis | bus.mem_icb_cmd_ready);
  assign bus.mem_icb_cmd_valid = ~rst & bus.lsu_req_valid & ~full & ~req_mis;
  assign bus.mem_icb_cmd_read  = bus.lsu_req_load;
  assign bus.mem_icb_cmd_addr  = bus.lsu_req_addr;

  assign push = bus.lsu_req_valid & bus.lsu_req_ready;

  always_comb begin
    bus.mem_icb_cmd_wdata = bus.lsu_req_wdata;
    bus.mem_icb_cmd_wmask = 4'b1111;
    case (bus.lsu_req_size)
      2'd0: begin
        bus.mem_icb_cmd_wdata = {4{bus.lsu_req_wdata[7:0]}};
        bus.mem_icb_cmd_wmask = 4'b0001 << bus.lsu_req_addr[1:0];
      end
      2'd1: begin
        bus.mem_icb_cmd_wdata = {2{bus.lsu_req_wdata[15:0]}};
        bus.mem_icb_cmd_wmask = 4'b0011 << bus.lsu_req_addr[1:0];
      end
      default: begin
        bus.mem_icb_cmd_wdata = bus.lsu_req_wdata;
        bus.mem_icb_cmd_wmask = 4'b1111;
      end
    endcase
  end

  assign head_load     = ent_load[rd_ptr];
  assign head_size     = ent_size[rd_ptr];
  assign head_unsigned = ent_unsigned[rd_ptr];
  assign head_off      = ent_off[rd_ptr];
  assign head_mis      = ent_mis[rd_ptr];

  // A misaligned head completes on its own; otherwise completion follows the bus response.
  assign bus.lsu_wb_valid      = ~rst & ~empty & (head_mis | bus.mem_icb_rsp_valid);
  assign bus.mem_icb_rsp_ready = ~rst & ~empty & ~head_mis & bus.lsu_wb_ready;
  assign bus.lsu_wb_rd         = ent_rd[rd_ptr];
  assign bus.lsu_wb_load       = head_load;
  assign bus.lsu_wb_misalign   = ~empty & head_mis;
  assign bus.lsu_wb_err        = ~empty & (head_mis | bus.mem_icb_rsp_err);

  assign pop = bus.lsu_wb_valid & bus.lsu_wb_ready;

  assign shifted = bus.mem_icb_rsp_rdata >> {head_off, 3'b000};

  always_comb begin
    load_data = bus.mem_icb_rsp_rdata;
    case (head_size)
      2'd0:    load_data = {{24{~head_unsigned & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{~head_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = bus.mem_icb_rsp_rdata;
    endcase
  end

  assign bus.lsu_wb_rdata = (head_load & ~head_mis) ? load_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_load[wr_ptr]     <= bus.lsu_req_load;
      ent_size[wr_ptr]     <= bus.lsu_req_size;
      ent_unsigned[wr_ptr] <= bus.lsu_req_unsigned;
      ent_off[wr_ptr]      <= bus.lsu_req_addr[1:0];
      ent_rd[wr_ptr]       <= bus.lsu_req_rd;
      ent_mis[wr_ptr]      <= req_mis;
    end
  end
endmodule

// File: tb/tb_hicore_lsu_icb_master.sv
// Bench for hicore_lsu_icb_master: directed scenarios plus a randomized stream
// scored against a queue-based model of the request/response rules.
module tb_hicore_lsu_icb_master;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct {
    bit        load;
    bit [1:0]  size;
    bit        uns;
    bit [1:0]  off;
    bit [4:0]  rd;
    bit        mis;
    bit [31:0] rdata;
    bit        err;
  } ent_t;

  ent_t q[$];

  hicore_lsu_icb_master_if #(.AW(32), .DW(32)) bus ();

  hicore_lsu_icb_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit is_mis(input bit [1:0] size, input logic [31:0] addr);
    return (size == 2'd1 && addr % 2 != 0) || (size >= 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] exp_wdata(input bit [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [3:0] exp_wmask(input bit [1:0] size, input bit [1:0] off);
    int m;
    if (size == 2'd0)      m = 1 << off;
    else if (size == 2'd1) m = 3 << off;
    else                   m = 15;
    return 4'(m);
  endfunction

  function automatic logic [31:0] exp_rdata(input ent_t e);
    logic [31:0] v;
    if (!e.load || e.mis) return 32'h0;
    v = e.rdata >> (8 * e.off);
    if (e.size == 2'd0) begin
      v = v & 32'hFF;
      if (!e.uns && v >= 32'd128) v = v - 32'd256;
    end else if (e.size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!e.uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = e.rdata;
    end
    return v;
  endfunction

  task automatic drive_req(input bit valid, input bit load, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit [1:0] size, input bit uns,
                           input bit [4:0] rd);
    bus.lsu_req_valid    = valid;
    bus.lsu_req_load     = load;
    bus.lsu_req_addr     = addr;
    bus.lsu_req_wdata    = wdata;
    bus.lsu_req_size     = size;
    bus.lsu_req_unsigned = uns;
    bus.lsu_req_rd       = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(1'b1, 1'b1, 32'h100, 32'h0, 2'd2, 1'b0, 5'd1);
    bus.mem_icb_cmd_ready = 1'b1;
    bus.lsu_wb_ready      = 1'b1;
    bus.mem_icb_rsp_valid = 1'b1;
    bus.mem_icb_rsp_err   = 1'b0;
    bus.mem_icb_rsp_rdata = 32'h12345678;
    #2;
    checks++; if (bus.lsu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", bus.lsu_req_ready); end
    checks++; if (bus.mem_icb_cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", bus.mem_icb_cmd_valid); end
    checks++; if (bus.mem_icb_rsp_ready !== 1'b0) begin failures++; $display("FAIL reset_rsp_ready got=%b exp=0", bus.mem_icb_rsp_ready); end
    checks++; if (bus.lsu_wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", bus.lsu_wb_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_icb_rsp_valid = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    #2;
    checks++; if (bus.lsu_wb_valid !== 1'b0) begin failures++; $display("FAIL post_reset_wb_valid got=%b exp=0", bus.lsu_wb_valid); end
    @(posedge clk); #1;
  endtask

  // One request through to its write-back with an always-ready bus.
  task automatic test_single_txn(input string name, input bit load, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit [1:0] size, input bit uns,
                                 input bit [4:0] rd, input logic [31:0] rdata, input bit err);
    ent_t e;
    logic [31:0] ev;
    e.load = load; e.size = size; e.uns = uns; e.off = addr[1:0]; e.rd = rd;
    e.mis = is_mis(size, addr); e.rdata = rdata; e.err = err;
    bus.mem_icb_cmd_ready = 1'b1;
    bus.lsu_wb_ready      = 1'b1;
    bus.mem_icb_rsp_valid = 1'b0;
    drive_req(1'b1, load, addr, wdata, size, uns, rd);
    #2;
    checks++; if (bus.lsu_req_ready !== 1'b1) begin failures++; $display("FAIL %s req_ready got=%b exp=1", name, bus.lsu_req_ready); end
    checks++; if (bus.mem_icb_cmd_valid !== ~e.mis) begin failures++; $display("FAIL %s cmd_valid got=%b exp=%b", name, bus.mem_icb_cmd_valid, ~e.mis); end
    if (!e.mis) begin
      checks++; if (bus.mem_icb_cmd_read !== load) begin failures++; $display("FAIL %s cmd_read got=%b exp=%b", name, bus.mem_icb_cmd_read, load); end
      checks++; if (bus.mem_icb_cmd_addr !== addr) begin failures++; $display("FAIL %s cmd_addr got=%h exp=%h", name, bus.mem_icb_cmd_addr, addr); end
      ev = exp_wdata(size, wdata);
      checks++; if (bus.mem_icb_cmd_wdata !== ev) begin failures++; $display("FAIL %s cmd_wdata got=%h exp=%h", name, bus.mem_icb_cmd_wdata, ev); end
      checks++; if (bus.mem_icb_cmd_wmask !== exp_wmask(size, e.off)) begin failures++; $display("FAIL %s cmd_wmask got=%b exp=%b", name, bus.mem_icb_cmd_wmask, exp_wmask(size, e.off)); end
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    if (!e.mis) begin
      bus.mem_icb_rsp_valid = 1'b1;
      bus.mem_icb_rsp_rdata = rdata;
      bus.mem_icb_rsp_err   = err;
    end
    #2;
    ev = exp_rdata(e);
    checks++; if (bus.lsu_wb_valid !== 1'b1) begin failures++; $display("FAIL %s wb_valid got=%b exp=1", name, bus.lsu_wb_valid); end
    checks++; if (bus.lsu_wb_rd !== rd) begin failures++; $display("FAIL %s wb_rd got=%0d exp=%0d", name, bus.lsu_wb_rd, rd); end
    checks++; if (bus.lsu_wb_load !== load) begin failures++; $display("FAIL %s wb_load got=%b exp=%b", name, bus.lsu_wb_load, load); end
    checks++; if (bus.lsu_wb_err !== (e.mis | err)) begin failures++; $display("FAIL %s wb_err got=%b exp=%b", name, bus.lsu_wb_err, e.mis | err); end
    checks++; if (bus.lsu_wb_misalign !== e.mis) begin failures++; $display("FAIL %s wb_misalign got=%b exp=%b", name, bus.lsu_wb_misalign, e.mis); end
    checks++; if (bus.lsu_wb_rdata !== ev) begin failures++; $display("FAIL %s wb_rdata got=%h exp=%h", name, bus.lsu_wb_rdata, ev); end
    checks++; if (bus.mem_icb_rsp_ready !== ~e.mis) begin failures++; $display("FAIL %s rsp_ready got=%b exp=%b", name, bus.mem_icb_rsp_ready, ~e.mis); end
    @(posedge clk); #1;
    bus.mem_icb_rsp_valid = 1'b0;
    bus.mem_icb_rsp_err   = 1'b0;
    #2;
    checks++; if (bus.lsu_wb_valid !== 1'b0) begin failures++; $display("FAIL %s drained_wb_valid got=%b exp=0", name, bus.lsu_wb_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    test_single_txn("st_byte",     1'b0, 32'h103, 32'hA5,       2'd0, 1'b0, 5'd3,  32'h1357_9BDF, 1'b0);
    test_single_txn("ld_byte_s",   1'b1, 32'h102, 32'h0,        2'd0, 1'b0, 5'd9,  32'h0080_FF00, 1'b0);
    test_single_txn("ld_byte_u",   1'b1, 32'h102, 32'h0,        2'd0, 1'b1, 5'd9,  32'h0080_FF00, 1'b0);
    test_single_txn("ld_half_u",   1'b1, 32'h202, 32'h0,        2'd1, 1'b1, 5'd12, 32'hBEEF_1234, 1'b0);
    test_single_txn("ld_half_s",   1'b1, 32'h200, 32'h0,        2'd1, 1'b0, 5'd13, 32'h1234_8001, 1'b0);
    test_single_txn("ld_word_mis", 1'b1, 32'h302, 32'h0,        2'd2, 1'b0, 5'd17, 32'h0,         1'b0);
    test_single_txn("st_half_mis", 1'b0, 32'h305, 32'hBEEF,     2'd1, 1'b0, 5'd18, 32'h0,         1'b0);
    test_single_txn("st_word_err", 1'b0, 32'h40C, 32'hCAFEF00D, 2'd2, 1'b0, 5'd20, 32'h0,         1'b1);
    test_single_txn("ld_rsvd_sz",  1'b1, 32'h410, 32'h0,        2'd3, 1'b0, 5'd21, 32'h8765_4321, 1'b0);
  endtask

  task automatic test_back_to_back();
    ent_t ea, eb, ec;
    ea = '{load:1'b1, size:2'd2, uns:1'b0, off:2'd0, rd:5'd5, mis:1'b0, rdata:$urandom, err:1'b0};
    eb = '{load:1'b1, size:2'd0, uns:1'b0, off:2'd1, rd:5'd6, mis:1'b0, rdata:$urandom, err:1'b0};
    ec = '{load:1'b1, size:2'd1, uns:1'b1, off:2'd2, rd:5'd7, mis:1'b0, rdata:$urandom, err:1'b0};
    bus.mem_icb_cmd_ready = 1'b1;
    bus.lsu_wb_ready      = 1'b0;
    bus.mem_icb_rsp_valid = 1'b0;
    drive_req(1'b1, 1'b1, 32'h400, 32'h0, 2'd2, 1'b0, 5'd5);
    #2;
    checks++; if (bus.mem_icb_cmd_valid !== 1'b1) begin failures++; $display("FAIL b2b_a_cmd_valid got=%b exp=1", bus.mem_icb_cmd_valid); end
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 32'h405, 32'h0, 2'd0, 1'b0, 5'd6);
    bus.mem_icb_rsp_valid = 1'b1;
    bus.mem_icb_rsp_rdata = ea.rdata;
    #2;
    checks++; if (bus.lsu_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_b_req_ready got=%b exp=1", bus.lsu_req_ready); end
    checks++; if (bus.mem_icb_rsp_ready !== 1'b0) begin failures++; $display("FAIL b2b_held_rsp_ready got=%b exp=0", bus.mem_icb_rsp_ready); end
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 32'h40A, 32'h0, 2'd1, 1'b1, 5'd7);
    #2;
    checks++; if (bus.lsu_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_c_stall_ready got=%b exp=0", bus.lsu_req_ready); end
    checks++; if (bus.mem_icb_cmd_valid !== 1'b0) begin failures++; $display("FAIL b2b_c_stall_cmd got=%b exp=0", bus.mem_icb_cmd_valid); end
    @(posedge clk); #1;
    bus.lsu_wb_ready = 1'b1;
    #2;
    checks++; if (bus.lsu_wb_rd !== ea.rd) begin failures++; $display("FAIL b2b_a_wb_rd got=%0d exp=%0d", bus.lsu_wb_rd, ea.rd); end
    checks++; if (bus.lsu_wb_rdata !== exp_rdata(ea)) begin failures++; $display("FAIL b2b_a_wb_rdata got=%h exp=%h", bus.lsu_wb_rdata, exp_rdata(ea)); end
    checks++; if (bus.lsu_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_pop_ready got=%b exp=0", bus.lsu_req_ready); end
    @(posedge clk); #1;
    bus.mem_icb_rsp_rdata = eb.rdata;
    #2;
    checks++; if (bus.mem_icb_cmd_valid !== 1'b1) begin failures++; $display("FAIL b2b_c_issue got=%b exp=1", bus.mem_icb_cmd_valid); end
    checks++; if (bus.lsu_wb_rd !== eb.rd) begin failures++; $display("FAIL b2b_b_wb_rd got=%0d exp=%0d", bus.lsu_wb_rd, eb.rd); end
    checks++; if (bus.lsu_wb_rdata !== exp_rdata(eb)) begin failures++; $display("FAIL b2b_b_wb_rdata got=%h exp=%h", bus.lsu_wb_rdata, exp_rdata(eb)); end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    bus.mem_icb_rsp_rdata = ec.rdata;
    #2;
    checks++; if (bus.lsu_wb_rd !== ec.rd) begin failures++; $display("FAIL b2b_c_wb_rd got=%0d exp=%0d", bus.lsu_wb_rd, ec.rd); end
    checks++; if (bus.lsu_wb_rdata !== exp_rdata(ec)) begin failures++; $display("FAIL b2b_c_wb_rdata got=%h exp=%h", bus.lsu_wb_rdata, exp_rdata(ec)); end
    @(posedge clk); #1;
    bus.mem_icb_rsp_valid = 1'b0;
    #2;
    checks++; if (bus.lsu_wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty_wb_valid got=%b exp=0", bus.lsu_wb_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bus.mem_icb_cmd_ready = 1'b1;
    bus.lsu_wb_ready      = 1'b0;
    bus.mem_icb_rsp_valid = 1'b0;
    drive_req(1'b1, 1'b1, 32'h500, 32'h0, 2'd2, 1'b0, 5'd10);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 32'h504, 32'h0, 2'd2, 1'b0, 5'd11);
    @(posedge clk); #1;
    bus.lsu_wb_ready      = 1'b1;
    bus.mem_icb_rsp_valid = 1'b1;
    bus.mem_icb_rsp_rdata = 32'hDEAD_BEEF;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.lsu_req_ready !== 1'b0) begin failures++; $display("FAIL midrst_req_ready got=%b exp=0", bus.lsu_req_ready); end
    checks++; if (bus.mem_icb_cmd_valid !== 1'b0) begin failures++; $display("FAIL midrst_cmd_valid got=%b exp=0", bus.mem_icb_cmd_valid); end
    checks++; if (bus.mem_icb_rsp_ready !== 1'b0) begin failures++; $display("FAIL midrst_rsp_ready got=%b exp=0", bus.mem_icb_rsp_ready); end
    checks++; if (bus.lsu_wb_valid !== 1'b0) begin failures++; $display("FAIL midrst_wb_valid got=%b exp=0", bus.lsu_wb_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    #2;
    checks++; if (bus.lsu_wb_valid !== 1'b0) begin failures++; $display("FAIL stale_wb_valid got=%b exp=0", bus.lsu_wb_valid); end
    checks++; if (bus.mem_icb_rsp_ready !== 1'b0) begin failures++; $display("FAIL stale_rsp_ready got=%b exp=0", bus.mem_icb_rsp_ready); end
    @(posedge clk); #1;
    bus.mem_icb_rsp_valid = 1'b0;
    test_single_txn("after_rst", 1'b1, 32'h600, 32'h0, 2'd1, 1'b0, 5'd22, 32'h0000_F00F, 1'b0);
  endtask

  // Random traffic with random back-pressure; the model is a plain in-order queue.
  task automatic test_random_stream();
    ent_t e;
    bit full, mis, exp_ready, exp_cmd, exp_wb, exp_rsp_ready, accepted, popped;
    logic [31:0] addr, wdata;
    bit [1:0] size;
    bit load, uns;
    bit [4:0] rd;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      size  = 2'($urandom_range(0, 3));
      load  = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      rd    = 5'($urandom);
      wdata = $urandom;
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size >= 2'd2) addr[1:0] = 2'b00;
      end
      drive_req((cyc < 570) && ($urandom_range(0, 3) != 0), load, addr, wdata, size, uns, rd);
      bus.mem_icb_cmd_ready = ($urandom_range(0, 3) != 0);
      bus.lsu_wb_ready      = ($urandom_range(0, 3) != 0);
      if (q.size() > 0 && !q[0].mis) begin
        bus.mem_icb_rsp_valid = ($urandom_range(0, 2) != 0);
        bus.mem_icb_rsp_rdata = q[0].rdata;
        bus.mem_icb_rsp_err   = q[0].err;
      end else if (q.size() == 0) begin
        bus.mem_icb_rsp_valid = ($urandom_range(0, 5) == 0);
        bus.mem_icb_rsp_rdata = $urandom;
        bus.mem_icb_rsp_err   = 1'($urandom_range(0, 1));
      end else begin
        bus.mem_icb_rsp_valid = 1'b0;
        bus.mem_icb_rsp_err   = 1'b0;
      end
      #2;
      full          = (q.size() == 2);
      mis           = is_mis(size, addr);
      exp_ready     = !full && (mis || bus.mem_icb_cmd_ready);
      exp_cmd       = bus.lsu_req_valid && !full && !mis;
      exp_wb        = (q.size() > 0) && (q[0].mis || bus.mem_icb_rsp_valid);
      exp_rsp_ready = (q.size() > 0) && !q[0].mis && bus.lsu_wb_ready;
      checks++; if (bus.lsu_req_ready !== exp_ready) begin failures++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, bus.lsu_req_ready, exp_ready); end
      checks++; if (bus.mem_icb_cmd_valid !== exp_cmd) begin failures++; $display("FAIL rnd_cmd_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_icb_cmd_valid, exp_cmd); end
      if (exp_cmd) begin
        checks++; if (bus.mem_icb_cmd_wdata !== exp_wdata(size, wdata)) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_icb_cmd_wdata, exp_wdata(size, wdata)); end
        checks++; if (bus.mem_icb_cmd_wmask !== exp_wmask(size, addr[1:0])) begin failures++; $display("FAIL rnd_wmask cyc=%0d got=%b exp=%b", cyc, bus.mem_icb_cmd_wmask, exp_wmask(size, addr[1:0])); end
      end
      checks++; if (bus.lsu_wb_valid !== exp_wb) begin failures++; $display("FAIL rnd_wb_valid cyc=%0d got=%b exp=%b", cyc, bus.lsu_wb_valid, exp_wb); end
      checks++; if (bus.mem_icb_rsp_ready !== exp_rsp_ready) begin failures++; $display("FAIL rnd_rsp_ready cyc=%0d got=%b exp=%b", cyc, bus.mem_icb_rsp_ready, exp_rsp_ready); end
      if (exp_wb) begin
        checks++; if (bus.lsu_wb_rd !== q[0].rd) begin failures++; $display("FAIL rnd_wb_rd cyc=%0d got=%0d exp=%0d", cyc, bus.lsu_wb_rd, q[0].rd); end
        checks++; if (bus.lsu_wb_rdata !== exp_rdata(q[0])) begin failures++; $display("FAIL rnd_wb_rdata cyc=%0d got=%h exp=%h", cyc, bus.lsu_wb_rdata, exp_rdata(q[0])); end
        checks++; if (bus.lsu_wb_err !== (q[0].mis | q[0].err)) begin failures++; $display("FAIL rnd_wb_err cyc=%0d got=%b exp=%b", cyc, bus.lsu_wb_err, q[0].mis | q[0].err); end
        checks++; if (bus.lsu_wb_misalign !== q[0].mis) begin failures++; $display("FAIL rnd_wb_misalign cyc=%0d got=%b exp=%b", cyc, bus.lsu_wb_misalign, q[0].mis); end
      end
      accepted = bus.lsu_req_valid && exp_ready;
      popped   = exp_wb && bus.lsu_wb_ready;
      @(posedge clk); #1;
      if (popped) void'(q.pop_front());
      if (accepted) begin
        e.load = load; e.size = size; e.uns = uns; e.off = addr[1:0]; e.rd = rd; e.mis = mis;
        e.rdata = $urandom; e.err = ($urandom_range(0, 7) == 0);
        q.push_back(e);
      end
    end
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    bus.mem_icb_rsp_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.lsu_req_valid     = 1'b0;
    bus.lsu_req_load      = 1'b0;
    bus.lsu_req_addr      = '0;
    bus.lsu_req_wdata     = '0;
    bus.lsu_req_size      = '0;
    bus.lsu_req_unsigned  = 1'b0;
    bus.lsu_req_rd        = '0;
    bus.lsu_wb_ready      = 1'b0;
    bus.mem_icb_cmd_ready = 1'b0;
    bus.mem_icb_rsp_valid = 1'b0;
    bus.mem_icb_rsp_err   = 1'b0;
    bus.mem_icb_rsp_rdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
